// File: rtl/bcd_seg_scanner_if.sv
// Valid/ready handshake carrying one packed BCD word {hundreds, tens, ones}.
//   bcd_in    : BCD word, [11:8] hundreds, [7:4] tens, [3:0] ones
//   bcd_valid : bcd_in is valid this cycle
//   bcd_ready : consumer can accept a word this cycle
// master = word producer, slave = bcd_seg_scanner.
interface bcd_seg_scanner_if;
    logic [11:0] bcd_in;
    logic        bcd_valid;
    logic        bcd_ready;

    modport master (output bcd_in, output bcd_valid, input bcd_ready);
    modport slave  (input bcd_in, input bcd_valid, output bcd_ready);
endinterface

// File: rtl/bcd_seg_scanner.sv
// Three-digit, common-anode, time-multiplexed 7-segment scanner fed by a
// valid/ready BCD word. Accepted words wait in a one-entry pending buffer
// and only reach the display at a frame boundary (hundreds -> ones wrap),
// so a frame never mixes digits from two words.
//   clk   : system clock, rising edge
//   rst_n : synchronous reset, active-low
//   bus   : slave side of the BCD handshake (bcd_in, bcd_valid, bcd_ready)
//   seg   : segments {g,f,e,d,c,b,a}, active-low, registered
//   an    : digit enables, active-low, an[0] ones .. an[2] hundreds, registered
//   err   : displayed word holds a nibble above 9, registered
//
// state    | meaning
// ST_BLANK | nothing shown yet; waiting for the first word
// ST_SCAN  | cycling ones -> tens -> hundreds, DIG_CYCLES cycles per digit
module bcd_seg_scanner #(
    parameter int DIG_CYCLES = 50000,
    parameter bit BLANK_LZ   = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_seg_scanner_if.slave   bus,
    output logic [6:0]         seg,
    output logic [2:0]         an,
    output logic               err
);
    localparam int CW = (DIG_CYCLES > 1) ? $clog2(DIG_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIG_CYCLES - 1);

    typedef enum logic {ST_BLANK, ST_SCAN} state_t;

    state_t        state, state_nxt;
    logic [11:0]   pending, pending_nxt;
    logic          pending_full, pending_full_nxt;
    logic [11:0]   disp, disp_nxt;
    logic [1:0]    idx, idx_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [6:0]    seg_nxt;
    logic [2:0]    an_nxt;
    logic          err_nxt;
    logic          accept;

    function automatic logic [6:0] seg_of(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = 7'h40;
            4'd1:    pat = 7'h79;
            4'd2:    pat = 7'h24;
            4'd3:    pat = 7'h30;
            4'd4:    pat = 7'h19;
            4'd5:    pat = 7'h12;
            4'd6:    pat = 7'h02;
            4'd7:    pat = 7'h78;
            4'd8:    pat = 7'h00;
            4'd9:    pat = 7'h10;
            default: pat = 7'h06;   // "E" for non-BCD nibbles
        endcase
        return pat;
    endfunction

    // A blanked digit keeps its anode lit with all segments off, so every
    // slot keeps the same on-time whether or not it is blanked.
    function automatic logic [6:0] digit_seg(input logic [11:0] word, input logic [1:0] sel);
        logic [3:0] nib;
        logic       blank;
        blank = 1'b0;
        case (sel)
            2'd0: nib = word[3:0];
            2'd1: begin
                nib   = word[7:4];
                blank = BLANK_LZ && (word[11:8] == 4'd0) && (word[7:4] == 4'd0);
            end
            2'd2: begin
                nib   = word[11:8];
                blank = BLANK_LZ && (word[11:8] == 4'd0);
            end
            default: begin
                nib   = 4'd0;
                blank = 1'b1;
            end
        endcase
        return blank ? 7'h7F : seg_of(nib);
    endfunction

    function automatic logic [2:0] an_of(input logic [1:0] sel);
        logic [2:0] a;
        case (sel)
            2'd0:    a = 3'b110;
            2'd1:    a = 3'b101;
            2'd2:    a = 3'b011;
            default: a = 3'b111;
        endcase
        return a;
    endfunction

    function automatic logic has_err(input logic [11:0] word);
        return (word[3:0] > 4'd9) || (word[7:4] > 4'd9) || (word[11:8] > 4'd9);
    endfunction

    assign bus.bcd_ready = ~pending_full;
    assign accept        = bus.bcd_valid && !pending_full;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_BLANK;
            pending      <= 12'h000;
            pending_full <= 1'b0;
            disp         <= 12'h000;
            idx          <= 2'd0;
            cnt          <= '0;
            seg          <= 7'h7F;
            an           <= 3'b111;
            err          <= 1'b0;
        end else begin
            state        <= state_nxt;
            pending      <= pending_nxt;
            pending_full <= pending_full_nxt;
            disp         <= disp_nxt;
            idx          <= idx_nxt;
            cnt          <= cnt_nxt;
            seg          <= seg_nxt;
            an           <= an_nxt;
            err          <= err_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        pending_nxt      = pending;
        pending_full_nxt = pending_full;
        disp_nxt         = disp;
        idx_nxt          = idx;
        cnt_nxt          = cnt;
        seg_nxt          = 7'h7F;
        an_nxt           = 3'b111;
        err_nxt          = 1'b0;

        case (state)
            ST_BLANK: begin
                if (pending_full) begin
                    disp_nxt         = pending;
                    pending_full_nxt = 1'b0;
                    state_nxt        = ST_SCAN;
                    idx_nxt          = 2'd0;
                    cnt_nxt          = '0;
                end
            end
            ST_SCAN: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt = '0;
                    if (idx == 2'd2) begin
                        idx_nxt = 2'd0;
                        if (pending_full) begin
                            disp_nxt         = pending;
                            pending_full_nxt = 1'b0;
                        end
                    end else begin
                        idx_nxt = idx + 2'd1;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = ST_BLANK;
        endcase

        // Accept and commit never coincide: accept needs an empty buffer,
        // commit needs a full one.
        if (accept) begin
            pending_nxt      = bus.bcd_in;
            pending_full_nxt = 1'b1;
        end

        // Outputs are registered from the post-edge scan position and word,
        // so an/seg/err always describe the same digit of the same word.
        if (state_nxt == ST_SCAN) begin
            an_nxt  = an_of(idx_nxt);
            seg_nxt = digit_seg(disp_nxt, idx_nxt);
            err_nxt = has_err(disp_nxt);
        end
    end
endmodule

// File: tb/tb_bcd_seg_scanner.sv
module tb_bcd_seg_scanner;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] tb_in = 12'h000;
    logic        tb_valid = 1'b0;

    always #5 clk = ~clk;

    localparam int DIGS [3] = '{4, 4, 1};
    localparam bit LZS  [3] = '{1'b1, 1'b0, 1'b1};
    localparam logic [6:0] SEGTAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06};

    bcd_seg_scanner_if bus0 ();
    bcd_seg_scanner_if bus1 ();
    bcd_seg_scanner_if bus2 ();
    assign bus0.bcd_in = tb_in;  assign bus0.bcd_valid = tb_valid;
    assign bus1.bcd_in = tb_in;  assign bus1.bcd_valid = tb_valid;
    assign bus2.bcd_in = tb_in;  assign bus2.bcd_valid = tb_valid;

    logic [6:0] seg0, seg1, seg2;
    logic [2:0] an0, an1, an2;
    logic       err0, err1, err2;

    bcd_seg_scanner #(.DIG_CYCLES(4), .BLANK_LZ(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .seg(seg0), .an(an0), .err(err0));
    bcd_seg_scanner #(.DIG_CYCLES(4), .BLANK_LZ(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .seg(seg1), .an(an1), .err(err1));
    bcd_seg_scanner #(.DIG_CYCLES(1), .BLANK_LZ(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2), .seg(seg2), .an(an2), .err(err2));

    logic [6:0] d_seg [3];
    logic [2:0] d_an  [3];
    logic       d_err [3];
    logic       d_rdy [3];
    assign d_seg[0] = seg0; assign d_seg[1] = seg1; assign d_seg[2] = seg2;
    assign d_an[0]  = an0;  assign d_an[1]  = an1;  assign d_an[2]  = an2;
    assign d_err[0] = err0; assign d_err[1] = err1; assign d_err[2] = err2;
    assign d_rdy[0] = bus0.bcd_ready;
    assign d_rdy[1] = bus1.bcd_ready;
    assign d_rdy[2] = bus2.bcd_ready;

    // Reference model: a word is "shown" from its commit edge; m_t counts
    // edges since the first commit, so the lit digit is (m_t / DIG) mod 3
    // and frame boundaries fall on multiples of 3*DIG.
    bit          m_init = 1'b0;
    bit          m_pf   [3];
    logic [11:0] m_pend [3];
    logic [11:0] m_disp [3];
    bit          m_scan [3];
    int          m_t    [3];
    bit          m_acc  [3];

    always @(posedge clk) begin
        if (!rst_n) begin
            m_init = 1'b1;
            for (int i = 0; i < 3; i++) begin
                m_pf[i] = 1'b0; m_pend[i] = 12'h000; m_disp[i] = 12'h000;
                m_scan[i] = 1'b0; m_t[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                m_acc[i] = tb_valid && !m_pf[i];
                if (!m_scan[i]) begin
                    if (m_pf[i]) begin
                        m_disp[i] = m_pend[i]; m_pf[i] = 1'b0;
                        m_scan[i] = 1'b1; m_t[i] = 0;
                    end
                end else begin
                    m_t[i] = m_t[i] + 1;
                    if ((m_t[i] % (3 * DIGS[i])) == 0 && m_pf[i]) begin
                        m_disp[i] = m_pend[i]; m_pf[i] = 1'b0;
                    end
                end
                if (m_acc[i]) begin
                    m_pend[i] = tb_in; m_pf[i] = 1'b1;
                end
            end
        end
    end

    function automatic logic [6:0] exp_seg(input logic [11:0] d, input int idx, input bit lz);
        logic [3:0] h, t, nib;
        h   = d[11:8];
        t   = d[7:4];
        nib = 4'((d >> (4 * idx)) & 12'h00F);
        if (lz && idx == 2 && h == 4'd0) return 7'h7F;
        if (lz && idx == 1 && h == 4'd0 && t == 4'd0) return 7'h7F;
        return SEGTAB[nib];
    endfunction

    function automatic logic exp_err(input logic [11:0] d);
        return (d[11:8] > 4'd9) || (d[7:4] > 4'd9) || (d[3:0] > 4'd9);
    endfunction

    // Hand-computed expectations for instances 0 and 1, set by the stimulus.
    bit         lit_on = 1'b0;
    logic [2:0] lit_an;
    logic [6:0] lit_seg;
    logic [6:0] lit_seg1;
    logic       lit_err;
    logic       lit_rdy;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int inst, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d t=%0t actual=%h required=%h", name, inst, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_init) begin
            for (int i = 0; i < 3; i++) begin
                int         idx;
                logic [2:0] ean;
                logic [6:0] eseg;
                logic       eerr;
                if (m_scan[i]) begin
                    idx  = (m_t[i] / DIGS[i]) % 3;
                    ean  = ~(3'b001 << idx);
                    eseg = exp_seg(m_disp[i], idx, LZS[i]);
                    eerr = exp_err(m_disp[i]);
                end else begin
                    ean = 3'b111; eseg = 7'h7F; eerr = 1'b0;
                end
                chk("an",    i, {9'd0, d_an[i]},  {9'd0, ean});
                chk("seg",   i, {5'd0, d_seg[i]}, {5'd0, eseg});
                chk("err",   i, {11'd0, d_err[i]}, {11'd0, eerr});
                chk("ready", i, {11'd0, d_rdy[i]}, {11'd0, !m_pf[i]});
            end
            if (lit_on) begin
                chk("lit_an",    0, {9'd0, an0},   {9'd0, lit_an});
                chk("lit_seg",   0, {5'd0, seg0},  {5'd0, lit_seg});
                chk("lit_seg",   1, {5'd0, seg1},  {5'd0, lit_seg1});
                chk("lit_err",   0, {11'd0, err0}, {11'd0, lit_err});
                chk("lit_ready", 0, {11'd0, bus0.bcd_ready}, {11'd0, lit_rdy});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        lit_on = 1'b0;
    endtask

    task automatic lit(input logic [2:0] a, input logic [6:0] s, input logic [6:0] s1,
                       input logic e, input logic r);
        lit_on = 1'b1; lit_an = a; lit_seg = s; lit_seg1 = s1; lit_err = e; lit_rdy = r;
    endtask

    function automatic logic [3:0] rnd_nib();
        int r;
        r = $urandom_range(0, 15);
        if (r < 4)  return 4'd0;
        if (r < 13) return 4'(r - 3);
        return 4'($urandom_range(10, 15));
    endfunction

    logic [2:0]  slot_an  [3] = '{3'b110, 3'b101, 3'b011};
    logic [6:0]  s123     [3] = '{7'h30, 7'h24, 7'h79};
    logic [6:0]  s007_lz  [3] = '{7'h78, 7'h7F, 7'h7F};
    logic [6:0]  s007_all [3] = '{7'h78, 7'h40, 7'h40};
    logic [11:0] words    [5] = '{12'h456, 12'h1A5, 12'h105, 12'h000, 12'h987};

    initial begin
        step();
        step();
        // after a reset edge
        lit(3'b111, 7'h7F, 7'h7F, 1'b0, 1'b1);
        rst_n = 1'b1; tb_valid = 1'b1; tb_in = 12'h123;
        step();                                   // after E0: accepted
        tb_valid = 1'b0;
        lit(3'b111, 7'h7F, 7'h7F, 1'b0, 1'b0);
        step();                                   // after E1: committed, ones lit
        lit(3'b110, 7'h30, 7'h30, 1'b0, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            step();
            lit(slot_an[k / 4], s123[k / 4], s123[k / 4], 1'b0, 1'b1);
        end
        rst_n = 1'b0;                             // reset lands mid hundreds slot
        step();
        lit(3'b111, 7'h7F, 7'h7F, 1'b0, 1'b1);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            lit(3'b111, 7'h7F, 7'h7F, 1'b0, 1'b1);
        end
        tb_valid = 1'b1; tb_in = 12'h007;
        step();
        tb_valid = 1'b0;
        lit(3'b111, 7'h7F, 7'h7F, 1'b0, 1'b0);
        step();
        lit(3'b110, 7'h78, 7'h78, 1'b0, 1'b1);
        for (int k = 1; k <= 11; k++) begin
            step();
            lit(slot_an[k / 4], s007_lz[k / 4], s007_all[k / 4], 1'b0, 1'b1);
        end

        // Directed words held valid long enough to be taken even while stalled.
        foreach (words[w]) begin
            tb_valid = 1'b1; tb_in = words[w];
            for (int k = 0; k < 20; k++) step();
        end
        tb_valid = 1'b0;
        for (int k = 0; k < 30; k++) step();

        // Random traffic, including stalled valids and occasional resets.
        for (int k = 0; k < 4000; k++) begin
            step();
            rst_n    = ($urandom_range(0, 399) != 0);
            tb_valid = ($urandom_range(0, 3) == 0);
            tb_in    = {rnd_nib(), rnd_nib(), rnd_nib()};
        end
        rst_n = 1'b1; tb_valid = 1'b0;
        for (int k = 0; k < 40; k++) step();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
